// File: rtl/pipelined_addsub.sv
// ============================================================================
// pipelined_addsub: W-bit add/subtract split into STAGES carry-rippled chunks,
// with a valid/ready handshake and whole-pipeline stall. Rev 1.0
// ============================================================================
`default_nettype none

module pipelined_addsub #(
    parameter int W      = 64,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    localparam int CW = W / STAGES;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [W-1:0]      opa_q [STAGES];
    logic [W-1:0]      opa_d [STAGES];
    logic [W-1:0]      opb_q [STAGES];
    logic [W-1:0]      opb_d [STAGES];
    logic [W-1:0]      res_q [STAGES];
    logic [W-1:0]      res_d [STAGES];

    logic              stall;
    logic [W-1:0]      b_cond;
    logic              c_cond;
    logic [CW:0]       chunk;

    assign stall    = vld_q[STAGES-1] && !out_ready;
    assign in_ready = !stall;
    assign b_cond   = b ^ {W{sub}};
    assign c_cond   = cin ^ sub;

    // Each stage adds its own chunk; operands and finished chunks ride along.
    // Data only moves with a valid beat so the output stage holds after a drain.
    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        opa_d = opa_q;
        opb_d = opb_q;
        res_d = res_q;
        chunk = '0;
        if (!stall) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                chunk          = {1'b0, a[CW-1:0]} + {1'b0, b_cond[CW-1:0]}
                               + {{CW{1'b0}}, c_cond};
                opa_d[0]       = a;
                opb_d[0]       = b_cond;
                res_d[0]       = '0;
                res_d[0][CW-1:0] = chunk[CW-1:0];
                cy_d[0]        = chunk[CW];
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    chunk    = {1'b0, opa_q[k-1][k*CW +: CW]}
                             + {1'b0, opb_q[k-1][k*CW +: CW]}
                             + {{CW{1'b0}}, cy_q[k-1]};
                    opa_d[k] = opa_q[k-1];
                    opb_d[k] = opb_q[k-1];
                    res_d[k] = res_q[k-1];
                    res_d[k][k*CW +: CW] = chunk[CW-1:0];
                    cy_d[k]  = chunk[CW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            res_q <= res_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign carry     = cy_q[STAGES-1];
    assign overflow  = (opa_q[STAGES-1][W-1] == opb_q[STAGES-1][W-1])
                    && (res_q[STAGES-1][W-1] != opa_q[STAGES-1][W-1]);

endmodule

`default_nettype wire

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, fully pipelined adder/subtractor; successor to the team's fixed 64-bit registered adder.
- Splits a W-bit operation into STAGES equal chunks, one chunk per pipeline stage, with the carry rippled between stages.
- Adds add/subtract mode, carry/borrow-in, signed overflow, and a valid/ready handshake with backpressure.
- Sits between operand-producing datapath logic and any consumer that may stall.

Parameters:
- W, 64, operand/result width in bits.
- STAGES, 4, pipeline depth and number of chunks; W must be divisible by STAGES; CW = W/STAGES.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  W  result
- carry  output  1  carry-out (add) / not-borrow (sub)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Operation: result = a + (b XOR {W{sub}}) + (cin XOR sub), taken modulo 2^(W+1).
  - sum = low W bits of the result; carry = bit W.
  - Consequence for sub: sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- overflow = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' is the conditioned b.
- Stall control:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - The whole pipeline advances on an edge only when !stall. On a stall edge every register holds.
- Accept: a beat is accepted on an edge where in_valid && in_ready.
  - Stage 1 captures the conditioned operands, sub, and the chunk-0 sum and carry.
  - Stage k (2..STAGES) computes chunk k-1 from the remaining operand bits and the carry out of stage k-1.
  - Unconsumed operand bits and finished sum chunks travel alongside the pipeline.
- Latency: the result is on sum/carry/overflow with out_valid=1 after exactly STAGES advancing edges, counting the accept edge.
  - Example: STAGES=4, no stalls, accept at edge 0 → out_valid high after edge 3.
- Bubbles:
  - When !stall and !(in_valid && in_ready), a valid=0 bubble enters stage 1.
  - Bubbles are not collapsed; throughput is 1 beat/cycle with no stalls.
- Output hold: while stall=1, sum, carry and overflow hold stable with out_valid=1.
  - A result leaves on the edge where out_valid && out_ready.
  - If the stage behind it is empty, out_valid drops on that edge.
- Per-stage valid bits form a shift register. Data registers of invalid stages are don't-care internally, except that the output registers only update when the incoming stage is valid.
- Reset (asserted asynchronously, any time):
  - All stage valid bits go to 0; out_valid=0, sum=0, carry=0, overflow=0.
  - In-flight beats are discarded; in_ready=1 from reset.
  - No spurious out_valid is allowed on the first edge after deassertion.
- STAGES=1: single registered stage; latency 1 edge.
- No combinational path from a/b/cin/sub to any output. The only combinational path is out_ready → in_ready.

Test Plan:
- Add, W=64, STAGES=4, out_ready=1: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 → after 4 edges: sum=0, carry=1, overflow=0.
- Subtract: a=5, b=7, sub=1, cin=0 → sum=0xFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0.
  - Then a=7, b=5 → sum=2, carry=1.
- Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add → sum=0x8000_0000_0000_0000, overflow=1, carry=0.
  - Then a=0x8000_0000_0000_0000, b=1, sub → sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Throughput/order: 16 back-to-back random beats with out_ready=1 → 16 results on consecutive cycles in order, each matching the reference model, first at edge 4.
- Backpressure: stream 8 beats while holding out_ready=0 for cycles 5-9.
  - in_ready=0 exactly while out_valid && !out_ready.
  - The output holds a stable value throughout.
  - No beat is lost or duplicated; the order is preserved.
- Reset mid-flight: accept 3 beats, assert rst asynchronously between edges → outputs go to 0 immediately.
  - After deassertion, no out_valid appears until a new beat has been accepted and completed 4 edges.
